ctrl_seq: RTL and testbench
===========================

Name: ctrl_seq

Overview:
- Multicycle control sequencer for the 16-bit datapath.
- Consumes the instruction register value and the 4-bit flag status. Drives every datapath control line: register-bank read/write selects and write enable, memory write, special-register load/tristate strobes, ALU op and flag update.
- Sits directly upstream of the register bank, memory, special registers and flag flip-flops.
- Moore FSM; one shared tristate bus, exactly one driver per cycle.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- HALT_OP, 4'hF, opcode that halts the sequencer.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (low at a rising edge = reset)
- en  in  1  advance enable; 0 = stall
- ir  in  16  current instruction: op=ir[15:12], rd/cond=ir[11:9], rs=ir[8:6]
- status  in  4  {S,V,Z,C} = status[3:0] as {s,v,z,c}
- rsel  out  3  register-bank read select
- wsel  out  3  register-bank write select
- wrr  out  1  register-bank write enable
- mrw  out  1  memory write strobe
- marl, irl, pcl, tl, zl, mdrl  out  1 each  special-register load strobes (MAR, IR, PC, ALU-operand T, ALU-result Z, MDR)
- pct, zt, memt  out  1 each  bus drive enables (PC, Z register, memory output)
- pcinc  out  1  PC increment strobe
- aluop  out  2  00 add, 01 sub, 10 and, 11 or
- sflag  out  1  flag register update
- halt  out  1  sequencer halted
- ill  out  1  illegal-opcode pulse (DEC cycle)
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - state<=F0, instret<=0.
  - While reset=0, every output other than instret is forced 0 combinationally.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR: rd<=rd op rs, flags updated
  - 5 LD: rd<=mem[rs]
  - 6 ST: mem[rd]<=rs
  - 7 BR: if cond then PC<=rs
  - HALT_OP: HLT
  - 8–14: illegal
- States and outputs (unlisted outputs are 0). Stall (en=0) is covered in the next bullet.
  - F0: pct, marl -> F1
  - F1: irl, pcinc -> DEC
  - DEC: no strobes; ill=1 for opcodes 8–14.
    - ALU ops -> A0; LD -> L0; ST -> S0.
    - BR -> B0 if cond true, else F0.
    - NOP / illegal -> F0.
    - HLT -> HALT.
  - A0: rsel=rd, tl -> A1
  - A1: rsel=rs, aluop=op-1, zl, sflag -> A2
  - A2: zt, wsel=rd, wrr -> F0
  - L0: rsel=rs, marl -> L1
  - L1: memt, wsel=rd, wrr -> F0
  - S0: rsel=rd, marl -> S1
  - S1: rsel=rs, mdrl -> S2
  - S2: mrw -> F0
  - B0: rsel=rs, pcl -> F0
  - HALT: halt=1, no strobes. Exits only via reset.
- Branch cond (ir[11:9]):
  - 000 always, 001 Z, 010 !Z, 011 C, 100 S, 101 V
  - 110, 111 never taken (no ill)
  - Evaluated from status sampled in DEC.
- Stall, en=0:
  - State holds.
  - All load/write strobes (wrr, mrw, marl, irl, pcl, pcinc, tl, zl, mdrl, sflag) forced 0; ill also forced 0.
  - rsel/wsel/aluop and bus enables keep their state values.
  - Each strobe is asserted for exactly one enabled cycle per visit.
- Retire: instret increments by 1 on the enabled edge leaving DEC (to F0), A2, L1, S2, B0, or entering HALT.
  - A not-taken branch and an illegal opcode count.
  - Wraps 2^CNT_W-1 -> 0.
- ir is sampled combinationally and is only meaningful from DEC onward. It must be stable DEC through the instruction's last state (IR loads only in F1).
- Bus exclusivity: at most one of pct, zt, memt, and register read per state. rsel drives the bank in A0, A1, L0, S0, S1, B0 only. rsel defaults to 0 elsewhere; the bank buffer is controlled by the datapath, not by this block.
- Reset mid-instruction: aborts at that edge, returns to F0. No strobe is asserted in the reset cycle.
- Latencies (cycles, en=1): ALU 6, LD 5, ST 6, BR taken 4, BR not-taken/NOP/illegal 3.

Test Plan:
- Reset low 2 cycles, release -> cycle 1 shows pct=1, marl=1; instret=0; all other strobes 0.
- ir=16'h1280 (ADD r1,r2), en=1 -> A0 rsel=1 tl; A1 rsel=2 aluop=00 zl sflag; A2 zt wsel=1 wrr. instret=1 after 6 cycles.
- ir=16'h6A40 (ST r1 -> [r5]) -> S0 rsel=5 marl; S1 rsel=1 mdrl; S2 mrw=1 for exactly one cycle.
- BR tests:
  - ir=16'h7280 (BR Z, rs=r2) with status=4'b0010 -> B0 rsel=2 pcl=1, 4 cycles.
  - Same with status=0 -> F0 after DEC, no pcl, instret still increments.
- en toggled 0 during A1 for 3 cycles -> rsel=2 held, zl/sflag 0 while stalled, asserted once when en returns.
- ir=16'h8000 -> ill=1 in DEC, then F0. ir=16'hF000 -> halt=1 held for 20 cycles, instret frozen. Reset clears it. Preset instret to 16'hFFFF via retirements -> wraps to 0.

Source files
------------

// File: rtl/ctrl_seq.sv
// Multicycle Moore control sequencer for the 16-bit datapath: walks fetch/decode/execute
// states and decodes every register-bank, memory, special-register and ALU control line.
module ctrl_seq #(
    parameter int unsigned CNT_W   = 16,
    parameter logic [3:0]  HALT_OP = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [15:0]      ir,
    input  logic [3:0]       status,
    output logic [2:0]       rsel,
    output logic [2:0]       wsel,
    output logic             wrr,
    output logic             mrw,
    output logic             marl,
    output logic             irl,
    output logic             pcl,
    output logic             tl,
    output logic             zl,
    output logic             mdrl,
    output logic             pct,
    output logic             zt,
    output logic             memt,
    output logic             pcinc,
    output logic [1:0]       aluop,
    output logic             sflag,
    output logic             halt,
    output logic             ill,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        ST_F0, ST_F1, ST_DEC, ST_A0, ST_A1, ST_A2, ST_L0, ST_L1,
        ST_S0, ST_S1, ST_S2, ST_B0, ST_HALT
    } state_t;

    state_t state, nxt;
    logic   retire;
    logic   taken;
    logic   illegal_op;

    logic [3:0] op;
    logic [2:0] rd, rs;
    logic       unused_ir;

    assign op        = ir[15:12];
    assign rd        = ir[11:9];
    assign rs        = ir[8:6];
    assign unused_ir = ^ir[5:0];

    // status is {s,v,z,c}; conditions 110/111 are never taken
    always_comb begin
        taken = 1'b0;
        case (rd)
            3'b000:  taken = 1'b1;
            3'b001:  taken = status[1];
            3'b010:  taken = ~status[1];
            3'b011:  taken = status[0];
            3'b100:  taken = status[3];
            3'b101:  taken = status[2];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt        = ST_F0;
        illegal_op = 1'b0;
        case (state)
            ST_F0:   nxt = ST_F1;
            ST_F1:   nxt = ST_DEC;
            ST_DEC: begin
                if (op == HALT_OP) begin
                    nxt = ST_HALT;
                end else begin
                    case (op)
                        4'd0:                 nxt = ST_F0;
                        4'd1, 4'd2, 4'd3, 4'd4: nxt = ST_A0;
                        4'd5:                 nxt = ST_L0;
                        4'd6:                 nxt = ST_S0;
                        4'd7:                 nxt = taken ? ST_B0 : ST_F0;
                        default: begin
                            nxt        = ST_F0;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
            end
            ST_A0:   nxt = ST_A1;
            ST_A1:   nxt = ST_A2;
            ST_L0:   nxt = ST_L1;
            ST_S0:   nxt = ST_S1;
            ST_S1:   nxt = ST_S2;
            ST_HALT: nxt = ST_HALT;
            default: nxt = ST_F0;
        endcase
    end

    // Retirement happens on the last state of each instruction, including HALT entry
    always_comb begin
        case (state)
            ST_DEC:                    retire = (nxt == ST_F0) || (nxt == ST_HALT);
            ST_A2, ST_L1, ST_S2, ST_B0: retire = 1'b1;
            default:                   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_F0;
            instret <= '0;
        end else if (en) begin
            state <= nxt;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        rsel  = '0;
        wsel  = '0;
        wrr   = 1'b0;
        mrw   = 1'b0;
        marl  = 1'b0;
        irl   = 1'b0;
        pcl   = 1'b0;
        tl    = 1'b0;
        zl    = 1'b0;
        mdrl  = 1'b0;
        pct   = 1'b0;
        zt    = 1'b0;
        memt  = 1'b0;
        pcinc = 1'b0;
        aluop = '0;
        sflag = 1'b0;
        halt  = 1'b0;
        ill   = 1'b0;
        case (state)
            ST_F0:   begin pct = 1'b1; marl = 1'b1; end
            ST_F1:   begin irl = 1'b1; pcinc = 1'b1; end
            ST_DEC:  ill = illegal_op;
            ST_A0:   begin rsel = rd; tl = 1'b1; end
            ST_A1:   begin rsel = rs; aluop = op[1:0] - 2'd1; zl = 1'b1; sflag = 1'b1; end
            ST_A2:   begin zt = 1'b1; wsel = rd; wrr = 1'b1; end
            ST_L0:   begin rsel = rs; marl = 1'b1; end
            ST_L1:   begin memt = 1'b1; wsel = rd; wrr = 1'b1; end
            ST_S0:   begin rsel = rd; marl = 1'b1; end
            ST_S1:   begin rsel = rs; mdrl = 1'b1; end
            ST_S2:   mrw = 1'b1;
            ST_B0:   begin rsel = rs; pcl = 1'b1; end
            ST_HALT: halt = 1'b1;
            default: ;
        endcase
        // A stall keeps selects and bus drivers but suppresses every state-changing strobe
        if (!en) begin
            wrr   = 1'b0;
            mrw   = 1'b0;
            marl  = 1'b0;
            irl   = 1'b0;
            pcl   = 1'b0;
            pcinc = 1'b0;
            tl    = 1'b0;
            zl    = 1'b0;
            mdrl  = 1'b0;
            sflag = 1'b0;
            ill   = 1'b0;
        end
        if (!reset) begin
            rsel  = '0;
            wsel  = '0;
            wrr   = 1'b0;
            mrw   = 1'b0;
            marl  = 1'b0;
            irl   = 1'b0;
            pcl   = 1'b0;
            tl    = 1'b0;
            zl    = 1'b0;
            mdrl  = 1'b0;
            pct   = 1'b0;
            zt    = 1'b0;
            memt  = 1'b0;
            pcinc = 1'b0;
            aluop = '0;
            sflag = 1'b0;
            halt  = 1'b0;
            ill   = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: per-cycle expected control vectors are queued per instruction
// and compared each cycle; a 4-bit-counter instance exercises instret wrap-around.
module tb_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic [15:0] ir = '0;
    logic [3:0]  status = '0;

    logic [2:0]  rsel, wsel;
    logic        wrr, mrw, marl, irl, pcl, tl, zl, mdrl, pct, zt, memt, pcinc, sflag, halt, ill;
    logic [1:0]  aluop;
    logic [15:0] instret;

    logic [2:0]  s_rsel, s_wsel;
    logic        s_wrr, s_mrw, s_marl, s_irl, s_pcl, s_tl, s_zl, s_mdrl, s_pct, s_zt, s_memt;
    logic        s_pcinc, s_sflag, s_halt, s_ill;
    logic [1:0]  s_aluop;
    logic [3:0]  s_instret;

    always #5 clk = ~clk;

    ctrl_seq #(.CNT_W(16), .HALT_OP(4'hF)) dut (
        .clk(clk), .reset(reset), .en(en), .ir(ir), .status(status),
        .rsel(rsel), .wsel(wsel), .wrr(wrr), .mrw(mrw), .marl(marl), .irl(irl),
        .pcl(pcl), .tl(tl), .zl(zl), .mdrl(mdrl), .pct(pct), .zt(zt), .memt(memt),
        .pcinc(pcinc), .aluop(aluop), .sflag(sflag), .halt(halt), .ill(ill),
        .instret(instret)
    );

    ctrl_seq #(.CNT_W(4), .HALT_OP(4'hF)) dut_small (
        .clk(clk), .reset(reset), .en(en), .ir(ir), .status(status),
        .rsel(s_rsel), .wsel(s_wsel), .wrr(s_wrr), .mrw(s_mrw), .marl(s_marl), .irl(s_irl),
        .pcl(s_pcl), .tl(s_tl), .zl(s_zl), .mdrl(s_mdrl), .pct(s_pct), .zt(s_zt), .memt(s_memt),
        .pcinc(s_pcinc), .aluop(s_aluop), .sflag(s_sflag), .halt(s_halt), .ill(s_ill),
        .instret(s_instret)
    );

    // {rsel, wsel, strobes[11:0], aluop, sflag, halt, ill}
    logic [22:0] dv;
    assign dv = {rsel, wsel, wrr, mrw, marl, irl, pcl, tl, zl, mdrl, pct, zt, memt, pcinc,
                 aluop, sflag, halt, ill};

    localparam logic [11:0] WRR = 12'h800, MRW = 12'h400, MARL = 12'h200, IRL = 12'h100;
    localparam logic [11:0] PCL = 12'h080, TL = 12'h040, ZL = 12'h020, MDRL = 12'h010;
    localparam logic [11:0] PCT = 12'h008, ZT = 12'h004, MEMT = 12'h002, PCINC = 12'h001;
    localparam logic [22:0] STALL_MASK = {3'h7, 3'h7, 12'h00E, 2'b11, 1'b0, 1'b1, 1'b0};

    typedef struct {
        string       tag;
        logic [22:0] v;
        logic        en;
        logic [15:0] cnt;
    } ent_t;

    ent_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_cnt = '0;
    int          k = 0;
    int          stall_idx = -1;
    int          stall_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [22:0] mk(input logic [2:0] rs, input logic [2:0] ws,
                                       input logic [11:0] st, input logic [1:0] op = 2'b00,
                                       input logic sf = 1'b0, input logic hl = 1'b0,
                                       input logic il = 1'b0);
        return {rs, ws, st, op, sf, hl, il};
    endfunction

    task automatic put(input string tag, input logic [22:0] v);
        ent_t e;
        if (k == stall_idx) begin
            for (int i = 0; i < stall_n; i++) begin
                e.tag = {tag, "-stall"}; e.v = v & STALL_MASK; e.en = 1'b0; e.cnt = exp_cnt;
                sb.push_back(e);
            end
        end
        e.tag = tag; e.v = v; e.en = 1'b1; e.cnt = exp_cnt;
        sb.push_back(e);
        k++;
    endtask

    // Expected per-cycle control vectors for one instruction, written from the state table
    task automatic push_instr(input logic [15:0] i, input logic taken);
        logic [3:0] op;
        logic [2:0] rd, rs;
        logic       il;
        op = i[15:12];
        rd = i[11:9];
        rs = i[8:6];
        il = (op >= 4'd8) && (op <= 4'd14);
        k = 0;
        put("F0", mk(3'd0, 3'd0, PCT | MARL));
        put("F1", mk(3'd0, 3'd0, IRL | PCINC));
        put("DEC", mk(3'd0, 3'd0, 12'h000, 2'b00, 1'b0, 1'b0, il));
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4: begin
                put("A0", mk(rd, 3'd0, TL));
                put("A1", mk(rs, 3'd0, ZL, (op == 4'd1) ? 2'b00 : (op == 4'd2) ? 2'b01 :
                                           (op == 4'd3) ? 2'b10 : 2'b11, 1'b1));
                put("A2", mk(3'd0, rd, ZT | WRR));
            end
            4'd5: begin
                put("L0", mk(rs, 3'd0, MARL));
                put("L1", mk(3'd0, rd, MEMT | WRR));
            end
            4'd6: begin
                put("S0", mk(rd, 3'd0, MARL));
                put("S1", mk(rs, 3'd0, MDRL));
                put("S2", mk(3'd0, 3'd0, MRW));
            end
            4'd7: if (taken) put("B0", mk(rs, 3'd0, PCL));
            4'd15: begin
                exp_cnt++;
                for (int j = 0; j < 20; j++)
                    put("HALT", mk(3'd0, 3'd0, 12'h000, 2'b00, 1'b0, 1'b1));
            end
            default: ;
        endcase
        if (op != 4'd15) exp_cnt++;
    endtask

    task automatic drain(input int lim);
        ent_t e;
        int   n;
        n = 0;
        while (sb.size() > 0 && (lim < 0 || n < lim)) begin
            e = sb.pop_front();
            en = e.en;
            @(negedge clk);
            check({e.tag, "/out"}, 32'(dv), 32'(e.v));
            check({e.tag, "/instret"}, 32'(instret), 32'(e.cnt));
            check({e.tag, "/instret4"}, 32'(s_instret), 32'(e.cnt[3:0]));
            @(posedge clk);
            #1;
            n++;
        end
        en = 1'b1;
    endtask

    task automatic run(input logic [15:0] i, input logic [3:0] st, input logic taken,
                       input int sidx = -1, input int sn = 0);
        ir = i;
        status = st;
        stall_idx = sidx;
        stall_n = sn;
        push_instr(i, taken);
        drain(-1);
        stall_idx = -1;
    endtask

    task automatic do_reset(input int n, input bit chk0);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst/out", 32'(dv), 32'h0);
            if (i > 0 || chk0) begin
                check("rst/instret", 32'(instret), (i == 0) ? 32'(exp_cnt) : 32'h0);
                check("rst/instret4", 32'(s_instret), (i == 0) ? 32'(exp_cnt[3:0]) : 32'h0);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        logic [15:0] saved;
        do_reset(2, 1'b0);
        run(16'h1280, 4'h0, 1'b0);            // ADD r1,r2
        run(16'h6A40, 4'h0, 1'b0);            // ST r1 -> [r5]
        run(16'h5700, 4'h0, 1'b0);            // LD r3 <- [r4]
        run(16'h7280, 4'b0010, 1'b1);         // BR Z taken
        run(16'h7280, 4'b0000, 1'b0);         // BR Z not taken
        run(16'h2280, 4'h0, 1'b0, 4, 3);      // SUB with 3-cycle stall in A1
        run(16'h3A40, 4'h0, 1'b0);            // AND
        run(16'h4A40, 4'h0, 1'b0, 2, 2);      // OR with stall in DEC
        run(16'h8000, 4'h0, 1'b0);            // illegal
        run(16'hE000, 4'h0, 1'b0, 2, 1);      // illegal, ill masked while stalled
        run(16'h0000, 4'h0, 1'b0);            // NOP
        run(16'h7C80, 4'hF, 1'b0);            // cond 110 never taken
        run(16'h7A80, 4'b0100, 1'b1);         // BR V taken
        for (int j = 0; j < 4; j++)
            run(16'h0000, 4'h0, 1'b0);        // 4-bit counter wraps 15 -> 0 here
        run(16'hF000, 4'h0, 1'b0);            // HLT, held 20 cycles
        do_reset(2, 1'b1);
        saved = exp_cnt;
        ir = 16'h1280;
        push_instr(16'h1280, 1'b0);
        drain(4);                             // abort ADD in A1
        sb.delete();
        exp_cnt = saved;
        do_reset(1, 1'b1);
        run(16'h0000, 4'h0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
